board_ram_arbiter: RTL and testbench
====================================

Name: board_ram_arbiter

Overview:
- Shares the single-port 256x6 board RAM among up to N_REQ requesters: collision checker, piece-lock writer, line-clear engine and board-clear sequencer.
- Round-robin arbitration with an optional per-requester lock, so multi-access sequences (e.g. 4-cell collision reads) run back-to-back.
- A starvation guard limits lock length.
- Sits between the game control FSM's sub-modules and the ram_board instance, replacing direct address muxing in the control FSM.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 8, RAM address width.
- DATA_W, 6, RAM data width (colour code per cell).
- RD_LAT, 1, RAM read latency in cycles: address-registered, output-unregistered RAM gives 1.
- MAX_LOCK, 16, maximum consecutive grant cycles one locked requester may hold.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- req  in  N_REQ  per-requester access request
- lock  in  N_REQ  per-requester: keep grant after this access
- we  in  N_REQ  per-requester: 1 = write, 0 = read
- addr  in  N_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
- wdata  in  N_REQ*DATA_W  flattened write data, same packing
- gnt  out  N_REQ  one-hot registered grant; access occurs in the cycle gnt[i]=1
- rvalid  out  N_REQ  pulses RD_LAT cycles after a granted read
- rdata  out  DATA_W  read data, valid when any rvalid bit is 1
- ram_addr  out  ADDR_W  to RAM address
- ram_wdata  out  DATA_W  to RAM data
- ram_wren  out  1  to RAM write enable
- ram_q  in  DATA_W  from RAM output

Behaviour:
- Reset: gnt=0, rvalid=0, RR pointer=N_REQ-1 (so requester 0 has first priority), lock counter=0. RAM outputs: ram_addr=0, ram_wdata=0, ram_wren=0 while no grant.
- Requester protocol: assert req with stable addr/we/wdata; hold until a cycle where gnt[i]=1. That cycle performs exactly one access. Under lock the requester may present a new addr/we/wdata every gnt cycle.
- Datapath:
  - ram_addr and ram_wdata are combinationally muxed from the granted requester.
  - ram_wren = gnt[i] & req[i] & we[i].
  - Granted cycle with req[i]=0: no access, wren=0.
- Grant register, updated every edge:
  - Keep: if owner i has gnt[i], req[i], lock[i] and lock count < MAX_LOCK-1, then gnt stays i and the counter increments.
  - Otherwise: next owner = first requester with req=1 searching from pointer+1 mod N_REQ upward.
    - The current owner's req is masked, since its req is still high in its grant cycle.
    - None found: gnt=0.
  - Pointer updates to the new owner on every new grant. The counter clears on every new grant or release.
- Lock release:
  - lock[i]=0 during a gnt cycle: that access is the last.
  - Lock timeout at MAX_LOCK consecutive cycles: forced release; the owner is masked for one arbitration even if still requesting.
  - Owner drops req while locked: grant released next edge, no access.
- Throughput:
  - A single unlocked requester gets at most one access every 2 cycles.
  - Competing requesters are granted back-to-back, with no idle cycle.
- Latency: req rising in cycle t with the RAM free gives gnt in t+1 and the access at the end of t+1. For a read, rvalid[i]=1 in cycle t+1+RD_LAT with rdata=ram_q passed through.
- rvalid pipeline: RD_LAT-deep shift of (gnt[i] & req[i] & ~we[i]). Multiple in-flight reads are allowed; each pulses in order.
- Simultaneous requests: RR from pointer, so no requester waits more than N_REQ-1 foreign grants, plus their lock lengths bounded by MAX_LOCK.
- Reset mid-operation: grant dropped and in-flight rvalid discarded at the reset edge; ram_wren=0 during reset.
- Out-of-range inputs: lock without req is ignored; gnt is never asserted to a requester with req=0 at the arbitration edge.

Test Plan:
- Single read: reset, req[0]=1, we=0, addr=8'h2A, RAM holds 6'h15 there -> gnt[0]=1 cycle 1, ram_addr=2A, ram_wren=0; rvalid[0]=1 cycle 2, rdata=6'h15; gnt[0]=0 cycle 2.
- Write then read-back: req[1] write addr 8'h10, wdata 6'h3F; then read 8'h10 -> ram_wren=1 exactly one cycle; read returns 6'h3F.
- Round-robin: req=4'b1111 held continuously, unlocked -> grant order 0,1,2,3,0,..., one grant per cycle, no gaps.
- Lock burst: req[2]&lock[2] with addrs 0,1,2,3 while req[0]=1 -> gnt[2] for 4 consecutive cycles; lock drops on addr 3; gnt[0] the next cycle; 4 rvalid[2] pulses in order.
- Lock timeout: req[3]&lock[3] held forever, req[1]=1 -> gnt[3] for exactly 16 cycles, then gnt[1] for 1 cycle, then gnt[3] again.
- Reset mid-read: assert reset_n=0 in the gnt cycle of a read -> next cycle gnt=0, rvalid=0, ram_wren=0; no stale rvalid after reset release.

Source files
------------

// File: rtl/board_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : board_ram_arbiter                                          |
// | Description : Round-robin arbiter with per-requester lock for the        |
// |               single-port board RAM.                                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module board_ram_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 6,
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          lock,
    input  logic [N_REQ-1:0]          we,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_wdata,
    output logic                      ram_wren,
    input  logic [DATA_W-1:0]         ram_q
);

    localparam int                 c_PTR_W    = $clog2(N_REQ);
    localparam int                 c_CNT_W    = $clog2(MAX_LOCK) + 1;
    localparam logic [c_CNT_W-1:0] c_LOCK_LIM = c_CNT_W'(MAX_LOCK - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_RST  = c_PTR_W'(N_REQ - 1);

    logic [N_REQ-1:0]              r_gnt;
    logic [c_PTR_W-1:0]            r_ptr;
    logic [c_CNT_W-1:0]            r_lock_cnt;
    logic [RD_LAT-1:0][N_REQ-1:0]  r_rv_pipe;

    logic [N_REQ-1:0]              w_req_m;
    logic [N_REQ-1:0]              w_next_gnt;
    logic [c_PTR_W-1:0]            w_idx;
    logic [c_PTR_W-1:0]            w_next_idx;
    logic                          w_found;
    logic                          w_keep;

    // The owner keeps the RAM only while it still requests, asks for lock,
    // and has not yet used up its lock budget.
    assign w_keep  = (|(r_gnt & req & lock)) && (r_lock_cnt < c_LOCK_LIM);
    assign w_req_m = req & ~r_gnt;

    always_comb begin
        w_found    = 1'b0;
        w_next_idx = '0;
        w_idx      = '0;
        w_next_gnt = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = c_PTR_W'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && w_req_m[w_idx]) begin
                w_found    = 1'b1;
                w_next_idx = w_idx;
            end
        end
        if (w_found) begin
            w_next_gnt[w_next_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_gnt      <= '0;
            r_ptr      <= c_PTR_RST;
            r_lock_cnt <= '0;
            r_rv_pipe  <= '0;
        end else begin
            r_rv_pipe[0] <= r_gnt & req & ~we;
            for (int k = 1; k < RD_LAT; k++) begin
                r_rv_pipe[k] <= r_rv_pipe[k-1];
            end
            if (w_keep) begin
                r_lock_cnt <= r_lock_cnt + c_CNT_W'(1);
            end else begin
                r_lock_cnt <= '0;
                r_gnt      <= w_next_gnt;
                if (w_found) begin
                    r_ptr <= w_next_idx;
                end
            end
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_gnt[i]) begin
                ram_addr  = addr[i*ADDR_W +: ADDR_W];
                ram_wdata = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Writes are suppressed while reset is held, even if a grant is still registered.
    assign ram_wren = reset_n & (|(r_gnt & req & we));
    assign gnt      = r_gnt;
    assign rvalid   = r_rv_pipe[RD_LAT-1];
    assign rdata    = ram_q;

endmodule
`default_nettype wire

// File: tb/tb_board_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_board_ram_arbiter                                       |
// | Description : Self-checking bench for board_ram_arbiter with RAM model.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_board_ram_arbiter;

    localparam int N_REQ    = 4;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 6;
    localparam int RD_LAT   = 1;
    localparam int MAX_LOCK = 16;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic [N_REQ-1:0]        req = '0;
    logic [N_REQ-1:0]        lock = '0;
    logic [N_REQ-1:0]        we = '0;
    logic [N_REQ*ADDR_W-1:0] addr = '0;
    logic [N_REQ*DATA_W-1:0] wdata = '0;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]       rdata;
    logic [ADDR_W-1:0]       ram_addr;
    logic [DATA_W-1:0]       ram_wdata;
    logic                    ram_wren;
    logic [DATA_W-1:0]       ram_q;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    board_ram_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .RD_LAT(RD_LAT), .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    // Board RAM: registered address, unregistered output.
    logic [DATA_W-1:0] mem [256];
    logic [ADDR_W-1:0] mem_raddr;
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        mem_raddr <= ram_addr;
    end
    assign ram_q = mem[mem_raddr];

    // Reference model: owner index (-1 = none), last winner, cycles held so far.
    int                m_owner;
    int                m_ptr;
    int                m_held;
    logic [N_REQ-1:0]  m_gnt;
    int                pv_own [RD_LAT];
    logic [DATA_W-1:0] pv_dat [RD_LAT];
    logic [DATA_W-1:0] shadow [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = N_REQ - 1;
        m_held  = 0;
        for (int k = 0; k < RD_LAT; k++) begin
            pv_own[k] = -1;
            pv_dat[k] = '0;
        end
    endtask

    task automatic settle_check();
        logic [N_REQ-1:0]  eg;
        logic [N_REQ-1:0]  erv;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        logic              ew;
        #1;
        eg = '0; erv = '0; ea = '0; ed = '0; ew = 1'b0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ea = addr[m_owner*ADDR_W +: ADDR_W];
            ed = wdata[m_owner*DATA_W +: DATA_W];
            ew = reset_n && req[m_owner] && we[m_owner];
        end
        if (pv_own[RD_LAT-1] >= 0) erv[pv_own[RD_LAT-1]] = 1'b1;
        m_gnt = eg;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("ram_wren", 32'(ram_wren), 32'(ew));
        chk("ram_addr", 32'(ram_addr), 32'(ea));
        chk("ram_wdata", 32'(ram_wdata), 32'(ed));
        chk("rvalid", 32'(rvalid), 32'(erv));
        if (erv != '0) chk("rdata", 32'(rdata), 32'(pv_dat[RD_LAT-1]));
    endtask

    task automatic model_edge();
        int a;
        int nxt;
        int c;
        if (!reset_n) begin
            model_reset();
            return;
        end
        for (int k = RD_LAT - 1; k > 0; k--) begin
            pv_own[k] = pv_own[k-1];
            pv_dat[k] = pv_dat[k-1];
        end
        pv_own[0] = -1;
        if (m_owner >= 0 && req[m_owner]) begin
            a = int'(addr[m_owner*ADDR_W +: ADDR_W]);
            if (we[m_owner]) shadow[a] = wdata[m_owner*DATA_W +: DATA_W];
            else begin
                pv_own[0] = m_owner;
                pv_dat[0] = shadow[a];
            end
        end
        if (m_owner >= 0 && req[m_owner] && lock[m_owner] && m_held < MAX_LOCK) begin
            m_held++;
        end else begin
            nxt = -1;
            for (int k = 1; k <= N_REQ; k++) begin
                c = (m_ptr + k) % N_REQ;
                if (nxt < 0 && c != m_owner && req[c]) nxt = c;
            end
            m_owner = nxt;
            if (nxt >= 0) begin
                m_ptr  = nxt;
                m_held = 1;
            end else begin
                m_held = 0;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic step();
        settle_check();
        advance();
    endtask

    task automatic set_req(input int i, input logic w, input logic l,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req[i] = 1'b1;
        we[i] = w;
        lock[i] = l;
        addr[i*ADDR_W +: ADDR_W] = a;
        wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic idle(input int n);
        req = '0;
        lock = '0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        req = '0;
        lock = '0;
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [N_REQ-1:0] last_g;
        for (int i = 0; i < 256; i++) begin
            mem[i] = DATA_W'($urandom);
            shadow[i] = mem[i];
        end
        mem[8'h2A] = 6'h15;
        shadow[8'h2A] = 6'h15;
        model_reset();
        m_gnt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        settle_check();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_wren", 32'(ram_wren), 32'h0);
        chk("rst_addr", 32'(ram_addr), 32'h0);
        advance();
        reset_n = 1'b1;
        step();

        // Single read of 0x2A by requester 0
        set_req(0, 1'b0, 1'b0, 8'h2A, 6'h00);
        step();
        settle_check();
        chk("rd_gnt", 32'(gnt), 32'h1);
        chk("rd_addr", 32'(ram_addr), 32'h2A);
        chk("rd_wren", 32'(ram_wren), 32'h0);
        advance();
        req = '0;
        settle_check();
        chk("rd_rvalid", 32'(rvalid), 32'h1);
        chk("rd_rdata", 32'(rdata), 32'h15);
        chk("rd_gnt_off", 32'(gnt), 32'h0);
        advance();

        // Write then read back by requester 1
        set_req(1, 1'b1, 1'b0, 8'h10, 6'h3F);
        step();
        settle_check();
        chk("wr_gnt", 32'(gnt), 32'h2);
        chk("wr_wren", 32'(ram_wren), 32'h1);
        chk("wr_wdata", 32'(ram_wdata), 32'h3F);
        advance();
        set_req(1, 1'b0, 1'b0, 8'h10, 6'h00);
        settle_check();
        chk("wr_once", 32'(ram_wren), 32'h0);
        advance();
        step();
        req = '0;
        settle_check();
        chk("rb_rdata", 32'(rdata), 32'h3F);
        advance();

        // Round robin with all requesters held
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_req(i, 1'b0, 1'b0, ADDR_W'(i + 4), 6'h00);
        step();
        for (int k = 0; k < 8; k++) begin
            settle_check();
            chk("rr_gnt", 32'(gnt), 32'(1 << (k % N_REQ)));
            advance();
        end
        idle(3);

        // Lock burst by requester 2 while requester 0 waits
        set_req(2, 1'b0, 1'b1, 8'h00, 6'h00);
        step();
        set_req(0, 1'b0, 1'b0, 8'h20, 6'h00);
        for (int k = 0; k < 4; k++) begin
            addr[2*ADDR_W +: ADDR_W] = ADDR_W'(k);
            if (k == 3) lock[2] = 1'b0;
            settle_check();
            chk("lk_gnt", 32'(gnt), 32'h4);
            if (k > 0) chk("lk_rvalid", 32'(rvalid), 32'h4);
            advance();
        end
        req[2] = 1'b0;
        settle_check();
        chk("lk_next", 32'(gnt), 32'h1);
        chk("lk_last_rv", 32'(rvalid), 32'h4);
        advance();
        idle(3);

        // Lock timeout: requester 3 locked forever, requester 1 waiting
        set_req(3, 1'b0, 1'b1, 8'h05, 6'h00);
        step();
        set_req(1, 1'b0, 1'b0, 8'h06, 6'h00);
        for (int k = 0; k < 18; k++) begin
            settle_check();
            chk("to_gnt", 32'(gnt), (k == 16) ? 32'h2 : 32'h8);
            advance();
            if (k == 16) req[1] = 1'b0;
        end
        idle(3);

        // Reset asserted in the grant cycle of a read
        do_reset();
        set_req(0, 1'b0, 1'b0, 8'h2A, 6'h00);
        step();
        reset_n = 1'b0;
        settle_check();
        chk("mr_gnt", 32'(gnt), 32'h1);
        chk("mr_wren", 32'(ram_wren), 32'h0);
        advance();
        reset_n = 1'b1;
        req = '0;
        settle_check();
        chk("mr_gnt_off", 32'(gnt), 32'h0);
        chk("mr_rvalid", 32'(rvalid), 32'h0);
        advance();
        settle_check();
        chk("mr_no_stale", 32'(rvalid), 32'h0);
        advance();

        // Randomized traffic against the model
        last_g = '0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!req[i] || last_g[i]) begin
                    req[i] = ($urandom_range(0, 99) < 55);
                    we[i] = 1'($urandom_range(0, 1));
                    lock[i] = ($urandom_range(0, 99) < 85);
                    addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 15));
                    wdata[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                end
            end
            settle_check();
            last_g = m_gnt;
            advance();
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
